// File: rtl/irrig_pkg.sv
// Shared types and constants for the irrigation sensor front end: FSM states,
// the 6-bit sensor vector layout and the tank-level consistency check.
package irrig_pkg;

  typedef enum logic {
    STABLE   = 1'b0,
    SETTLING = 1'b1
  } state_t;

  typedef logic [5:0] sensor_vec_t;

  // Bit positions inside sensor_vec_t
  localparam int unsigned H  = 5;
  localparam int unsigned M  = 4;
  localparam int unsigned L  = 3;
  localparam int unsigned AS = 2;
  localparam int unsigned GT = 1;
  localparam int unsigned C  = 0;

  // A higher probe wet while a lower one is dry cannot be a real water level.
  function automatic logic level_fault(input sensor_vec_t v);
    return (v[H] & ~v[M]) | (v[M] & ~v[L]) | (v[H] & ~v[L]);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous input bit, cleared by rst_n.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic ff1_q, ff1_d;
  logic ff2_q, ff2_d;

  always_comb begin
    ff1_d = d;
    ff2_d = ff1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff1_q <= 1'b0;
      ff2_q <= 1'b0;
    end else begin
      ff1_q <= ff1_d;
      ff2_q <= ff2_d;
    end
  end

  assign q = ff2_q;

endmodule

// File: rtl/sensor_sampler.sv
// Debounces six asynchronous sensor inputs and strobes accepted values and periodic
// refreshes to the digit decoder. Optional macro SENSOR_FAULT_EN enables level-probe fault masking.
module sensor_sampler
  import irrig_pkg::*;
#(
  parameter int DEB_CYCLES  = 16,
  parameter int REFRESH_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic h_raw,
  input  logic m_raw,
  input  logic l_raw,
  input  logic as_raw,
  input  logic gt_raw,
  input  logic c_raw,
  output logic h,
  output logic m,
  output logic l,
  output logic As,
  output logic Gt,
  output logic _C_,
  output logic pulse,
  output logic sensor_err
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

  sensor_vec_t raw_vec;
  sensor_vec_t s_vec;

  assign raw_vec = {h_raw, m_raw, l_raw, as_raw, gt_raw, c_raw};

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_sync
      sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (raw_vec[gi]),
        .q     (s_vec[gi])
      );
    end
  endgenerate

  state_t          state_q, state_d;
  sensor_vec_t     acc_q, acc_d;
  sensor_vec_t     cand_q, cand_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   ref_q, ref_d;
  sensor_vec_t     out_q, out_d;
  logic            pulse_q, pulse_d;
  logic            err_q, err_d;
  logic            commit;
  sensor_vec_t     commit_vec;
  logic            refresh_hit;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    ref_d       = ref_q;
    out_d       = out_q;
    err_d       = err_q;
    commit      = 1'b0;
    commit_vec  = cand_q;
    refresh_hit = (ref_q == REF_LAST);

    // A commit is held off while pulse_q is high so strobes never touch back to back.
    unique case (state_q)
      STABLE: begin
        if (s_vec != acc_q) begin
          if (DEB_CYCLES == 1 && !pulse_q) begin
            commit     = 1'b1;
            commit_vec = s_vec;
          end else begin
            cand_d  = s_vec;
            cnt_d   = CW'(1);
            state_d = SETTLING;
          end
        end
      end
      SETTLING: begin
        if (s_vec == acc_q) begin
          state_d = STABLE;
        end else if (s_vec != cand_q) begin
          if (DEB_CYCLES == 1 && !pulse_q) begin
            commit     = 1'b1;
            commit_vec = s_vec;
            state_d    = STABLE;
          end else begin
            cand_d = s_vec;
            cnt_d  = CW'(1);
          end
        end else if (cnt_q == DEB_LAST) begin
          if (!pulse_q) begin
            commit  = 1'b1;
            state_d = STABLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = STABLE;
    endcase

    if (commit) begin
      acc_d = commit_vec;
      out_d = commit_vec;
`ifdef SENSOR_FAULT_EN
      if (level_fault(commit_vec)) begin
        err_d    = 1'b1;
        out_d[H] = out_q[H];
        out_d[M] = out_q[M];
        out_d[L] = out_q[L];
      end else begin
        err_d = 1'b0;
      end
`endif
    end
`ifndef SENSOR_FAULT_EN
    err_d = 1'b0;
`endif

    pulse_d = commit | refresh_hit;
    ref_d   = pulse_d ? '0 : ref_q + RW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STABLE;
      acc_q   <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      ref_q   <= '0;
      out_q   <= '0;
      pulse_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      ref_q   <= ref_d;
      out_q   <= out_d;
      pulse_q <= pulse_d;
      err_q   <= err_d;
    end
  end

  assign h          = out_q[H];
  assign m          = out_q[M];
  assign l          = out_q[L];
  assign As         = out_q[AS];
  assign Gt         = out_q[GT];
  assign _C_        = out_q[C];
  assign pulse      = pulse_q;
  assign sensor_err = err_q;

endmodule

// File: tb/tb_sensor_sampler.sv
// Scoreboard bench for sensor_sampler (DEB_CYCLES=4, REFRESH_DIV=32): stimulus pushes
// expected pulses, a negedge monitor pops and compares them and checks outputs hold in between.
module tb_sensor_sampler;

  localparam int DEB  = 4;
  localparam int RDIV = 32;
  localparam int LAT  = DEB + 3;  // drive at negedge of cycle k -> visible after edge k+1+2+DEB

`ifdef SENSOR_FAULT_EN
  localparam logic [5:0] V_BAD = 6'b011101;
  localparam logic       E_BAD = 1'b1;
`else
  localparam logic [5:0] V_BAD = 6'b101101;
  localparam logic       E_BAD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic h_raw = 1'b0, m_raw = 1'b0, l_raw = 1'b0;
  logic as_raw = 1'b0, gt_raw = 1'b0, c_raw = 1'b0;
  logic h, m, l, As, Gt, _C_, pulse, sensor_err;
  logic [5:0] outs;

  sensor_sampler #(.DEB_CYCLES(DEB), .REFRESH_DIV(RDIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .h_raw      (h_raw),
    .m_raw      (m_raw),
    .l_raw      (l_raw),
    .as_raw     (as_raw),
    .gt_raw     (gt_raw),
    .c_raw      (c_raw),
    .h          (h),
    .m          (m),
    .l          (l),
    .As         (As),
    .Gt         (Gt),
    ._C_        (_C_),
    .pulse      (pulse),
    .sensor_err (sensor_err)
  );

  always #5 clk = ~clk;
  assign outs = {h, m, l, As, Gt, _C_};

  typedef struct {
    int         cyc;
    logic [5:0] vec;
    logic       err;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc;
  int         checks = 0;
  int         failures = 0;
  logic [5:0] cur_vec;
  logic       cur_err;
  logic       prev_pulse;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_pulse(input int c, input logic [5:0] v, input logic e);
    exp_t x;
    x.cyc = c;
    x.vec = v;
    x.err = e;
    exp_q.push_back(x);
  endtask

  task automatic set_raw(input logic [5:0] v);
    {h_raw, m_raw, l_raw, as_raw, gt_raw, c_raw} = v;
  endtask

  task automatic wait_cyc(input int k);
    while (cyc != k) @(negedge clk);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      cur_vec    = '0;
      cur_err    = 1'b0;
      prev_pulse = 1'b0;
    end else begin
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check("missed_pulse", 32'(cyc), 32'(exp_q[0].cyc));
        void'(exp_q.pop_front());
      end
      if (pulse) begin
        check("double_pulse", 32'(prev_pulse), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pulse_cycle", 32'(cyc), 32'(e.cyc));
          check("pulse_outs", 32'(outs), 32'(e.vec));
          check("pulse_err", 32'(sensor_err), 32'(e.err));
          $display("pulse at cyc %0d outs=%b err=%0d (expected cyc %0d outs=%b err=%0d)",
                   cyc, outs, sensor_err, e.cyc, e.vec, e.err);
          cur_vec = e.vec;
          cur_err = e.err;
        end
      end else begin
        check("hold_outs", 32'(outs), 32'(cur_vec));
        check("hold_err", 32'(sensor_err), 32'(cur_err));
      end
      prev_pulse = pulse;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_raw(6'b000000);
    repeat (3) @(negedge clk);
    check("reset_outs", 32'(outs), 32'd0);
    check("reset_pulse", 32'(pulse), 32'd0);
    check("reset_err", 32'(sensor_err), 32'd0);
    rst_n = 1'b1;

    // Idle: only the refresh strobe
    expect_pulse(RDIV, 6'b000000, 1'b0);
    wait_cyc(40);

    // Raise l; refresh restarts from the commit
    set_raw(6'b001000);
    expect_pulse(40 + LAT, 6'b001000, 1'b0);
    expect_pulse(40 + LAT + RDIV, 6'b001000, 1'b0);

    // Short m glitch: nothing
    wait_cyc(55); set_raw(6'b011000);
    wait_cyc(58); set_raw(6'b001000);

    wait_cyc(85); set_raw(6'b000000);
    expect_pulse(85 + LAT, 6'b000000, 1'b0);

    // 001 then 011 two cycles later: single commit of 011
    wait_cyc(100); set_raw(6'b001000);
    wait_cyc(102); set_raw(6'b011000);
    expect_pulse(102 + LAT, 6'b011000, 1'b0);

    // Inconsistent levels h=1 m=0 l=1 plus As and _C_
    wait_cyc(115); set_raw(6'b101101);
    expect_pulse(115 + LAT, V_BAD, E_BAD);

    wait_cyc(130); set_raw(6'b111101);
    expect_pulse(130 + LAT, 6'b111101, 1'b0);

    // Reset in the middle of settling (CNT == 2)
    wait_cyc(145); set_raw(6'b110101);
    wait_cyc(149);
    rst_n = 1'b0;
    #1;
    check("midrst_outs", 32'(outs), 32'd0);
    check("midrst_pulse", 32'(pulse), 32'd0);
    check("midrst_err", 32'(sensor_err), 32'd0);
    check("midrst_queue", 32'(exp_q.size()), 32'd0);
    set_raw(6'b000000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // After release only the refresh at REFRESH_DIV may pulse
    expect_pulse(RDIV, 6'b000000, 1'b0);
    wait_cyc(RDIV + 8);
    check("final_queue", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
